// File: rtl/clave_entry.sv
// Keypad code-entry front end: debounced key events, BCD code collection, lockout.
// Optional duress code enabled by defining CLAVE_DURESS_EN.
module clave_entry #(
  parameter int DIGITS = 4,
  parameter logic [4*DIGITS-1:0] CODE = 16'h1234,
  parameter int CW = 31,
  parameter int DEB_LIMIT = 1_000_000,
  parameter int TIMEOUT_LIMIT = 250_000_000,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_LIMIT = 1_500_000_000
`ifdef CLAVE_DURESS_EN
  ,
  parameter logic [4*DIGITS-1:0] DURESS_CODE = 16'h1235
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic [3:0] key_code,
  output logic       clave,
  output logic       err_pulse,
  output logic       locked,
  output logic [3:0] digit_cnt,
  output logic       duress
);

  localparam int BW = 4 * DIGITS;
  localparam int FW = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, LOCKED} state_t;

  logic [1:0]    sync_q;
  logic          deb_level;
  logic [CW-1:0] deb_cnt;
  logic          key_evt;
  logic [3:0]    key_val;

  state_t        state;
  logic [BW-1:0] code_buf;
  logic          bad;
  logic [FW-1:0] fail_cnt;
  logic [FW-1:0] fail_inc;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] lock_cnt;
  logic          is_digit;
  logic          code_ok;

  // Synchroniser and debouncer; an event fires only on a debounced rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      key_evt   <= 1'b0;
      key_val   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_press};
      key_evt <= 1'b0;
      if (sync_q[1] == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt >= CW'(DEB_LIMIT - 1)) begin
        deb_level <= sync_q[1];
        deb_cnt   <= '0;
        key_evt   <= sync_q[1];
        key_val   <= key_code;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign is_digit = (key_val <= 4'd9);
  assign fail_inc = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;
  assign code_ok  = (digit_cnt == 4'(DIGITS)) && !bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      code_buf  <= '0;
      digit_cnt <= '0;
      bad       <= 1'b0;
      fail_cnt  <= '0;
      tmo_cnt   <= '0;
      lock_cnt  <= '0;
      clave     <= 1'b0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
`ifdef CLAVE_DURESS_EN
      duress    <= 1'b0;
`endif
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          // A key event always wins over a timeout expiring in the same cycle
          if (key_evt && is_digit) begin
            if (digit_cnt == 4'(DIGITS)) begin
              bad <= 1'b1;
            end else begin
              code_buf  <= (code_buf << 4) | BW'(key_val);
              digit_cnt <= digit_cnt + 1'b1;
            end
            tmo_cnt <= '0;
            state   <= ENTRY;
          end else if (key_evt && key_val == 4'hF) begin
            code_buf  <= '0;
            digit_cnt <= '0;
            bad       <= 1'b0;
            state     <= IDLE;
          end else if (key_evt && key_val == 4'hE) begin
            state <= CHECK;
          end else if (state == ENTRY) begin
            if (tmo_cnt >= CW'(TIMEOUT_LIMIT - 1)) begin
              code_buf  <= '0;
              digit_cnt <= '0;
              bad       <= 1'b0;
              tmo_cnt   <= '0;
              state     <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          code_buf  <= '0;
          digit_cnt <= '0;
          bad       <= 1'b0;
          tmo_cnt   <= '0;
          if (code_ok && code_buf == CODE) begin
            clave    <= 1'b1;
            fail_cnt <= '0;
            state    <= OPEN;
`ifdef CLAVE_DURESS_EN
          end else if (code_ok && code_buf == DURESS_CODE) begin
            clave    <= 1'b1;
            duress   <= 1'b1;
            fail_cnt <= '0;
            state    <= OPEN;
`endif
          end else begin
            err_pulse <= 1'b1;
            fail_cnt  <= fail_inc;
            if (fail_inc == FW'(MAX_FAIL)) begin
              locked   <= 1'b1;
              lock_cnt <= '0;
              state    <= LOCKED;
            end else begin
              state <= IDLE;
            end
          end
        end
        OPEN: begin
          if (key_evt && key_val == 4'hA) begin
            clave <= 1'b0;
`ifdef CLAVE_DURESS_EN
            duress <= 1'b0;
`endif
            state <= IDLE;
          end
        end
        LOCKED: begin
          if (lock_cnt >= CW'(LOCK_LIMIT - 1)) begin
            locked   <= 1'b0;
            fail_cnt <= '0;
            lock_cnt <= '0;
            state    <= IDLE;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef CLAVE_DURESS_EN
  assign duress = 1'b0;
`endif

endmodule

// File: tb/tb_clave_entry.sv
// Directed bench for clave_entry with short debounce/timeout/lock limits.
// Covers the duress code path when CLAVE_DURESS_EN is defined.
module tb_clave_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_press;
  logic [3:0] key_code;
  logic       clave;
  logic       err_pulse;
  logic       locked;
  logic [3:0] digit_cnt;
  logic       duress;

  int vectors = 0;
  int miscompares = 0;
  int err_seen = 0;
  int err_base;

`ifdef CLAVE_DURESS_EN
  localparam logic [3:0] BAD_LAST = 4'd6;
`else
  localparam logic [3:0] BAD_LAST = 4'd5;
`endif

  clave_entry #(
    .DEB_LIMIT(4),
    .TIMEOUT_LIMIT(50),
    .LOCK_LIMIT(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_press(key_press),
    .key_code(key_code),
    .clave(clave),
    .err_pulse(err_pulse),
    .locked(locked),
    .digit_cnt(digit_cnt),
    .duress(duress)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err_pulse === 1'b1) err_seen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One clean key: held 10 cycles, released 10 cycles
  task automatic applyStimulus(input logic [3:0] code);
    key_code  = code;
    key_press = 1'b1;
    repeat (10) @(negedge clk);
    key_press = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic enterCode(input logic [3:0] last);
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(last);
    applyStimulus(4'hE);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    key_press = 1'b0;
    key_code  = 4'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_clave", 32'(clave), 0);
    checkOutput("rst_err", 32'(err_pulse), 0);
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_digits", 32'(digit_cnt), 0);
    checkOutput("rst_duress", 32'(duress), 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(4'd1);
    checkOutput("digits_1", 32'(digit_cnt), 1);
    applyStimulus(4'd2);
    checkOutput("digits_2", 32'(digit_cnt), 2);
    applyStimulus(4'd3);
    checkOutput("digits_3", 32'(digit_cnt), 3);
    applyStimulus(4'd4);
    checkOutput("digits_4", 32'(digit_cnt), 4);

    // Enter: event after 6 edges, CHECK after 7, clave after 8
    key_code  = 4'hE;
    key_press = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("clave_early", 32'(clave), 0);
    @(negedge clk);
    checkOutput("clave_on_time", 32'(clave), 1);
    repeat (2) @(negedge clk);
    key_press = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("open_err", 32'(err_seen), 0);

    applyStimulus(4'd7);
    checkOutput("open_ignore_digit", 32'(clave), 1);
    applyStimulus(4'hA);
    checkOutput("rearm_clave", 32'(clave), 0);
    checkOutput("rearm_duress", 32'(duress), 0);

    err_base = err_seen;
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'd4);
    applyStimulus(4'd5);
    checkOutput("overlen_sat", 32'(digit_cnt), 4);
    applyStimulus(4'hE);
    checkOutput("overlen_err", 32'(err_seen - err_base), 1);
    checkOutput("overlen_clave", 32'(clave), 0);
    checkOutput("overlen_clear", 32'(digit_cnt), 0);

    applyStimulus(4'hE);
    checkOutput("empty_enter_err", 32'(err_seen - err_base), 2);
    checkOutput("empty_enter_lock", 32'(locked), 0);

    key_code = 4'd5;
    for (int i = 0; i < 10; i++) begin
      key_press = ~key_press;
      repeat (2) @(negedge clk);
    end
    key_press = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("bounce_digits", 32'(digit_cnt), 0);

    applyStimulus(4'd1);
    applyStimulus(4'd2);
    checkOutput("tmo_before", 32'(digit_cnt), 2);
    repeat (60) @(negedge clk);
    checkOutput("tmo_digits", 32'(digit_cnt), 0);
    checkOutput("tmo_err", 32'(err_seen - err_base), 2);
    checkOutput("tmo_locked", 32'(locked), 0);

    // Two failures still stand, so one more bad code locks
    enterCode(BAD_LAST);
    checkOutput("third_fail_lock", 32'(locked), 1);
    pulseReset();
    checkOutput("rst_lock_locked", 32'(locked), 0);
    checkOutput("rst_lock_clave", 32'(clave), 0);

    err_base = err_seen;
    enterCode(BAD_LAST);
    checkOutput("fail1_lock", 32'(locked), 0);
    enterCode(BAD_LAST);
    checkOutput("fail2_lock", 32'(locked), 0);
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(BAD_LAST);
    key_code  = 4'hE;
    key_press = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("lock_early", 32'(locked), 0);
    @(negedge clk);
    checkOutput("lock_start", 32'(locked), 1);
    repeat (2) @(negedge clk);
    key_press = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("lock_err3", 32'(err_seen - err_base), 3);
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    checkOutput("lock_ignore_digits", 32'(digit_cnt), 0);
    checkOutput("lock_clave", 32'(clave), 0);
    repeat (27) @(negedge clk);
    checkOutput("lock_last_cycle", 32'(locked), 1);
    @(negedge clk);
    checkOutput("lock_release", 32'(locked), 0);

    enterCode(BAD_LAST);
    enterCode(BAD_LAST);
    checkOutput("post_lock_failcnt", 32'(locked), 0);
    enterCode(4'd4);
    checkOutput("valid_after_fails", 32'(clave), 1);
    pulseReset();
    checkOutput("rst_open_clave", 32'(clave), 0);
    enterCode(BAD_LAST);
    checkOutput("rst_open_failcnt", 32'(locked), 0);

`ifdef CLAVE_DURESS_EN
    pulseReset();
    enterCode(4'd5);
    checkOutput("duress_clave", 32'(clave), 1);
    checkOutput("duress_flag", 32'(duress), 1);
    applyStimulus(4'hA);
    checkOutput("duress_rearm_clave", 32'(clave), 0);
    checkOutput("duress_rearm_flag", 32'(duress), 0);
`endif

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
